// File: rtl/div_pipe_param_pkg.sv
// div_pipe_param_pkg: remainder sign encodings and latency helper for the pipelined divider
package div_pipe_param_pkg;
   typedef enum logic {REM_MAG = 1'b0, REM_NUMER = 1'b1} rem_mode_e;
   function automatic int latency(input int widthn);
      return widthn + 2;
   endfunction
endpackage

// File: rtl/div_pipe_param_stage.sv
// div_pipe_param_stage: one restoring step, shifts in one quotient bit (MSB first)
module div_pipe_param_stage #(
   parameter int WIDTHN = 27,
   parameter int WIDTHD = 21,
   parameter int TAG_W  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clken,
   input  logic              i_valid,
   input  logic [TAG_W-1:0]  i_tag,
   input  logic              i_nsign,
   input  logic              i_dsign,
   input  logic              i_dbz,
   input  logic [WIDTHD-1:0] i_rem,
   input  logic [WIDTHN-1:0] i_n,
   input  logic [WIDTHD-1:0] i_d,
   output logic              o_valid,
   output logic [TAG_W-1:0]  o_tag,
   output logic              o_nsign,
   output logic              o_dsign,
   output logic              o_dbz,
   output logic [WIDTHD-1:0] o_rem,
   output logic [WIDTHN-1:0] o_n,
   output logic [WIDTHD-1:0] o_d
);
   logic [WIDTHD:0]   w_trial;
   logic              w_ge;
   logic [WIDTHD-1:0] w_rem;
   assign w_trial = {i_rem, i_n[WIDTHN-1]};
   assign w_ge    = w_trial >= {1'b0, i_d};
   assign w_rem   = w_ge ? WIDTHD'(w_trial - {1'b0, i_d}) : w_trial[WIDTHD-1:0];
   always_ff @(posedge clk)
      if (reset) o_valid <= 1'b0;
      else if (clken) o_valid <= i_valid;
   // o_n doubles as numerator shifter and quotient accumulator
   always_ff @(posedge clk)
      if (clken) begin
         o_tag   <= i_tag;
         o_nsign <= i_nsign;
         o_dsign <= i_dsign;
         o_dbz   <= i_dbz;
         o_rem   <= w_rem;
         o_n     <= {i_n[WIDTHN-2:0], w_ge};
         o_d     <= i_d;
      end
endmodule

// File: rtl/div_pipe_param.sv
// div_pipe_param: fully pipelined signed/unsigned divider, WIDTHN+2 enabled cycles latency
// Input stage takes magnitudes, WIDTHN restoring stages, output stage restores signs.
module div_pipe_param
   import div_pipe_param_pkg::*;
#(
   parameter int WIDTHN   = 27,
   parameter int WIDTHD   = 21,
   parameter int SIGNED   = 0,
   parameter int REM_MODE = 0,
   parameter int TAG_W    = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clken,
   input  logic              in_valid,
   input  logic [TAG_W-1:0]  in_tag,
   input  logic [WIDTHN-1:0] numer,
   input  logic [WIDTHD-1:0] denom,
   output logic              out_valid,
   output logic [TAG_W-1:0]  out_tag,
   output logic [WIDTHN-1:0] quotient,
   output logic [WIDTHD-1:0] remain,
   output logic              div_by_zero
);
   logic              w_v   [0:WIDTHN];
   logic [TAG_W-1:0]  w_tag [0:WIDTHN];
   logic              w_ns  [0:WIDTHN];
   logic              w_ds  [0:WIDTHN];
   logic              w_z   [0:WIDTHN];
   logic [WIDTHD-1:0] w_rem [0:WIDTHN];
   logic [WIDTHN-1:0] w_n   [0:WIDTHN];
   logic [WIDTHD-1:0] w_d   [0:WIDTHN];
   logic              r_v, r_ns, r_ds, r_z;
   logic [TAG_W-1:0]  r_tag;
   logic [WIDTHN-1:0] r_n;
   logic [WIDTHD-1:0] r_d;
   logic              w_nneg, w_dneg, w_rneg;
   assign w_nneg = (SIGNED != 0) && numer[WIDTHN-1];
   assign w_dneg = (SIGNED != 0) && denom[WIDTHD-1];
   always_ff @(posedge clk)
      if (reset) r_v <= 1'b0;
      else if (clken) r_v <= in_valid;
   // negating the most negative value yields 2^(W-1), which is the correct unsigned magnitude
   always_ff @(posedge clk)
      if (clken) begin
         r_tag <= in_tag;
         r_ns  <= w_nneg;
         r_ds  <= w_dneg;
         r_z   <= denom == '0;
         r_n   <= w_nneg ? -numer : numer;
         r_d   <= w_dneg ? -denom : denom;
      end
   assign w_v[0]   = r_v;
   assign w_tag[0] = r_tag;
   assign w_ns[0]  = r_ns;
   assign w_ds[0]  = r_ds;
   assign w_z[0]   = r_z;
   assign w_rem[0] = '0;
   assign w_n[0]   = r_n;
   assign w_d[0]   = r_d;
   for (genvar i = 0; i < WIDTHN; i++) begin : g_stage
      div_pipe_param_stage #(.WIDTHN(WIDTHN), .WIDTHD(WIDTHD), .TAG_W(TAG_W)) u_stage (
         .clk(clk), .reset(reset), .clken(clken),
         .i_valid(w_v[i]), .i_tag(w_tag[i]), .i_nsign(w_ns[i]), .i_dsign(w_ds[i]), .i_dbz(w_z[i]),
         .i_rem(w_rem[i]), .i_n(w_n[i]), .i_d(w_d[i]),
         .o_valid(w_v[i+1]), .o_tag(w_tag[i+1]), .o_nsign(w_ns[i+1]), .o_dsign(w_ds[i+1]), .o_dbz(w_z[i+1]),
         .o_rem(w_rem[i+1]), .o_n(w_n[i+1]), .o_d(w_d[i+1])
      );
   end
   assign w_rneg = (REM_MODE == int'(REM_NUMER)) && w_ns[WIDTHN];
   always_ff @(posedge clk)
      if (reset) begin
         out_valid   <= 1'b0;
         out_tag     <= '0;
         quotient    <= '0;
         remain      <= '0;
         div_by_zero <= 1'b0;
      end else if (clken) begin
         out_valid   <= w_v[WIDTHN];
         out_tag     <= w_tag[WIDTHN];
         div_by_zero <= w_v[WIDTHN] & w_z[WIDTHN];
         quotient    <= w_z[WIDTHN] ? '1 : (w_ns[WIDTHN] ^ w_ds[WIDTHN]) ? -w_n[WIDTHN] : w_n[WIDTHN];
         remain      <= w_z[WIDTHN] ? '0 : w_rneg ? -w_rem[WIDTHN] : w_rem[WIDTHN];
      end
endmodule

// File: tb/tb_div_pipe_param.sv
// tb_div_pipe_param: three divider flavours on shared stimulus, checked against an arithmetic scoreboard
module tb_div_pipe_param;
   localparam int LAT = 29;
   typedef struct {
      int               e;
      logic [3:0]       tag;
      logic [2:0][26:0] q;
      logic [2:0][20:0] r;
      logic             z;
   } ent_t;
   logic        clk = 1'b0, reset, clken, in_valid;
   logic [3:0]  in_tag;
   logic [26:0] numer;
   logic [20:0] denom;
   logic        ov [3];
   logic [3:0]  ot [3];
   logic [26:0] oq [3];
   logic [20:0] orm [3];
   logic        oz [3];
   ent_t        sb[$];
   ent_t        cur;
   logic        ev;
   int          ecnt, total, bad;
   logic [3:0]  tg;
   always #5 clk = ~clk;
   div_pipe_param #(.SIGNED(0), .REM_MODE(0)) u_uns (.clk(clk), .reset(reset), .clken(clken), .in_valid(in_valid),
      .in_tag(in_tag), .numer(numer), .denom(denom), .out_valid(ov[0]), .out_tag(ot[0]), .quotient(oq[0]),
      .remain(orm[0]), .div_by_zero(oz[0]));
   div_pipe_param #(.SIGNED(1), .REM_MODE(0)) u_smag (.clk(clk), .reset(reset), .clken(clken), .in_valid(in_valid),
      .in_tag(in_tag), .numer(numer), .denom(denom), .out_valid(ov[1]), .out_tag(ot[1]), .quotient(oq[1]),
      .remain(orm[1]), .div_by_zero(oz[1]));
   div_pipe_param #(.SIGNED(1), .REM_MODE(1)) u_snum (.clk(clk), .reset(reset), .clken(clken), .in_valid(in_valid),
      .in_tag(in_tag), .numer(numer), .denom(denom), .out_valid(ov[2]), .out_tag(ot[2]), .quotient(oq[2]),
      .remain(orm[2]), .div_by_zero(oz[2]));
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask
   function automatic ent_t model(input logic [26:0] n, input logic [20:0] d, input logic [3:0] t, input int e);
      ent_t   x;
      longint nu = n, du = d, ns = $signed(n), ds = $signed(d), qs, rs;
      x.e = e; x.tag = t; x.z = (d == 0);
      if (x.z) begin
         for (int k = 0; k < 3; k++) begin x.q[k] = '1; x.r[k] = '0; end
      end else begin
         qs = ns / ds;
         rs = ns % ds;
         x.q[0] = 27'(nu / du); x.r[0] = 21'(nu % du);
         x.q[1] = 27'(qs);      x.r[1] = 21'(rs < 0 ? -rs : rs);
         x.q[2] = 27'(qs);      x.r[2] = 21'(rs);
      end
      return x;
   endfunction
   task automatic tick(input logic v, input logic ce, input logic [26:0] n, input logic [20:0] d, input logic [3:0] t);
      in_valid = v; clken = ce; numer = n; denom = d; in_tag = t;
      @(posedge clk);
      if (reset) begin
         sb.delete();
         ev = 1'b0;
      end else if (ce) begin
         ecnt++;
         if (v) sb.push_back(model(n, d, t, ecnt));
         ev = 1'b0;
         if (sb.size() != 0 && sb[0].e + LAT - 1 == ecnt) begin
            cur = sb.pop_front();
            ev = 1'b1;
         end
      end
      #1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("valid%0d", k), 64'(ov[k]), 64'(ev));
         if (ev) begin
            chk($sformatf("tag%0d", k), 64'(ot[k]), 64'(cur.tag));
            chk($sformatf("quot%0d", k), 64'(oq[k]), 64'(cur.q[k]));
            chk($sformatf("rem%0d", k), 64'(orm[k]), 64'(cur.r[k]));
            chk($sformatf("dbz%0d", k), 64'(oz[k]), 64'(cur.z));
         end
      end
   endtask
   task automatic issue(input logic [26:0] n, input logic [20:0] d);
      tick(1'b1, 1'b1, n, d, tg);
      tg++;
   endtask
   task automatic idle(input int c);
      for (int i = 0; i < c; i++) tick(1'b0, 1'b1, 27'($urandom), 21'($urandom), 4'($urandom));
   endtask
   logic [26:0] dn [8] = '{27'd8, 27'd8, 27'h7FFFFF3, 27'd100, 27'd15, 27'h4000000, 27'h7FFFFFF, 27'h4000000};
   logic [20:0] dd [8] = '{21'd3, 21'h1FFFFD, 21'd3, 21'd0, 21'd4, 21'h1FFFFF, 21'h1FFFFF, 21'd1};
   initial begin
      total = 0; bad = 0; ecnt = 0; ev = 1'b0; tg = 4'd5;
      reset = 1'b1;
      tick(1'b0, 1'b1, '0, '0, '0);
      tick(1'b0, 1'b1, '0, '0, '0);
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("rst_quot", 64'(oq[k]), 64'd0);
         chk("rst_rem", 64'(orm[k]), 64'd0);
         chk("rst_tag", 64'(ot[k]), 64'd0);
         chk("rst_dbz", 64'(oz[k]), 64'd0);
      end
      // directed: 8/3, signed cases, divide by zero then recovery, overflow, extremes
      for (int i = 0; i < 8; i++) issue(dn[i], dd[i]);
      idle(35);
      // 16 back-to-back with a 5-cycle freeze mid-stream; the frozen inputs must be ignored
      for (int i = 0; i < 16; i++) begin
         if (i == 8) for (int j = 0; j < 5; j++) tick(1'b1, 1'b0, 27'($urandom), 21'($urandom), 4'($urandom));
         if (i == 3) issue(27'h7FFFFFF, 21'h1FFFFF);
         else issue(27'($urandom), 21'($urandom_range(1, 21'h1FFFFF)));
      end
      idle(35);
      // reset with ops in flight, asserted while clken is low: reset still wins
      for (int i = 0; i < 10; i++) issue(27'($urandom), 21'($urandom));
      reset = 1'b1;
      tick(1'b1, 1'b0, 27'd1, 21'd1, 4'd0);
      reset = 1'b0;
      idle(40);
      for (int i = 0; i < 400; i++) begin
         logic [26:0] n;
         logic [20:0] d;
         n = ($urandom % 8 == 0) ? 27'h4000000 : 27'($urandom);
         case ($urandom % 6)
            0: d = '0;
            1: d = 21'h1FFFFF;
            2: d = 21'($urandom_range(1, 15));
            default: d = 21'($urandom);
         endcase
         tick(1'($urandom % 4 != 0), 1'($urandom % 5 != 0), n, d, tg);
         tg++;
      end
      idle(40);
      chk("drained", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
